// File: rtl/mem_responder.sv
// mem_responder: single-port word memory answering reads after a fixed
// LATENCY through a valid/data/addr shift pipeline. Writes commit at the
// accepting edge. Reads are returned in order. flush and rst squash reads
// that are in flight.
module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        flush,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [15:0] addr_out,
    output logic        busy,
    output logic [3:0]  outstanding
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    // addr[0] selects a byte lane and is ignored. Bits above DEPTH_LOG2
    // alias onto the same words.
    logic [DEPTH_LOG2-1:0] word_idx;
    assign word_idx = addr[DEPTH_LOG2:1];

    logic accept_read;
    logic accept_write;
    assign accept_read  = enable && !wr && !rst;
    assign accept_write = enable &&  wr && !rst;

    logic [15:0] mem_reg   [WORDS];
    logic        valid_reg [LATENCY];
    logic [15:0] data_reg  [LATENCY];
    logic [15:0] addr_reg  [LATENCY];
    logic [3:0]  inflight_count;

    // Write port. The array is deliberately not reset, so its contents
    // survive rst.
    always_ff @(posedge clk) begin
        if (accept_write) begin
            mem_reg[word_idx] <= data_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // Stage 0 loads on the accepting edge. A flush on the same
                // edge does not stop the new read from entering.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        valid_reg[0] <= 1'b0;
                    end else begin
                        valid_reg[0] <= accept_read;
                    end
                end

                // Registered read. Because it is a nonblocking read, it
                // returns the pre-write contents of the word.
                always_ff @(posedge clk) begin
                    if (accept_read) begin
                        data_reg[0] <= mem_reg[word_idx];
                        addr_reg[0] <= addr;
                    end
                end
            end else begin : g_tail
                // Later stages carry valid forward. A flush or rst clears
                // them, so the reads they hold are never returned.
                always_ff @(posedge clk) begin
                    if (rst || flush) begin
                        valid_reg[gi] <= 1'b0;
                    end else begin
                        valid_reg[gi] <= valid_reg[gi-1];
                    end
                end

                // The data and address payload shifts every cycle. The
                // valid bit alone decides whether it is meaningful.
                always_ff @(posedge clk) begin
                    data_reg[gi] <= data_reg[gi-1];
                    addr_reg[gi] <= addr_reg[gi-1];
                end
            end
        end
    endgenerate

    // Reads in flight = number of valid stages, including the one that is
    // returning now.
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight_count = inflight_count + {3'b000, valid_reg[i]};
        end
    end

    assign data_valid  = valid_reg[LATENCY-1];
    assign data_out    = data_valid ? data_reg[LATENCY-1] : 16'h0000;
    assign addr_out    = data_valid ? addr_reg[LATENCY-1] : 16'h0000;
    assign outstanding = inflight_count;
    assign busy        = (inflight_count != 4'd0);

endmodule
